// File: rtl/main_control_fsm.sv
// Multi-cycle main control unit for the 16-bit CPU.
// Decodes opcode/funct and sequences fetch, decode, execute, memory and
// writeback, driving alu_op to the downstream ALU-control decoder.
// Optional feature macro: MEM_TIMEOUT_EN adds a memory wait counter that
// aborts to a sticky bus-error state after TIMEOUT_CYCLES cycles without mem_ack.
module main_control_fsm #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic [3:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       jr,
    output logic       halted,
    output logic       illegal,
    output logic       bus_err
);

    typedef enum logic [4:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_WB_R,
        S_EXEC_I,
        S_WB_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_JR,
        S_HALT,
        S_ILLEGAL,
        S_BUS_ERR
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_SLTI  = 4'b0010;
    localparam logic [3:0] OP_LW    = 4'b0011;
    localparam logic [3:0] OP_SW    = 4'b0100;
    localparam logic [3:0] OP_BEQ   = 4'b0101;
    localparam logic [3:0] OP_J     = 4'b0110;
    localparam logic [3:0] OP_JAL   = 4'b0111;
    localparam logic [3:0] OP_HALT  = 4'b1111;
    localparam logic [3:0] FN_JR    = 4'b1000;

    state_t r_state;
    state_t w_stateNext;
    logic   w_isWait;
    logic   w_timeout;
    logic   w_unused;

    // The zero flag is consumed by the datapath through pc_write_cond, not here.
    assign w_unused = zero | (TIMEOUT_CYCLES == 0);

    // The three states that hold a memory request open until mem_ack.
    assign w_isWait = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] r_waitCnt;

    // Count unanswered request cycles; restart whenever the FSM changes state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waitCnt <= '0;
        end else if (w_stateNext != r_state) begin
            r_waitCnt <= '0;
        end else if (w_isWait && !mem_ack) begin
            r_waitCnt <= r_waitCnt + 1'b1;
        end
    end

    // The TIMEOUT_CYCLES-th unanswered cycle aborts; an ack in that cycle still wins.
    assign w_timeout = w_isWait && !mem_ack && (r_waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state selection.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:     w_stateNext = S_FETCH;
            S_FETCH: begin
                if (mem_ack)        w_stateNext = S_DECODE;
                else if (w_timeout) w_stateNext = S_BUS_ERR;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:       w_stateNext = (funct == FN_JR) ? S_JR : S_EXEC_R;
                    OP_ADDI,
                    OP_SLTI:        w_stateNext = S_EXEC_I;
                    OP_LW,
                    OP_SW:          w_stateNext = S_MEM_ADDR;
                    OP_BEQ:         w_stateNext = S_BRANCH;
                    OP_J,
                    OP_JAL:         w_stateNext = S_JUMP;
                    OP_HALT:        w_stateNext = S_HALT;
                    default:        w_stateNext = S_ILLEGAL;
                endcase
            end
            S_EXEC_R:   w_stateNext = S_WB_R;
            S_WB_R:     w_stateNext = S_FETCH;
            S_EXEC_I:   w_stateNext = S_WB_I;
            S_WB_I:     w_stateNext = S_FETCH;
            S_MEM_ADDR: w_stateNext = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ack)        w_stateNext = S_MEM_WB;
                else if (w_timeout) w_stateNext = S_BUS_ERR;
            end
            S_MEM_WB:   w_stateNext = S_FETCH;
            S_MEM_WR: begin
                if (mem_ack)        w_stateNext = S_FETCH;
                else if (w_timeout) w_stateNext = S_BUS_ERR;
            end
            S_BRANCH:   w_stateNext = S_FETCH;
            S_JUMP:     w_stateNext = S_FETCH;
            S_JR:       w_stateNext = S_FETCH;
            S_HALT:     w_stateNext = S_HALT;
            S_ILLEGAL:  w_stateNext = S_ILLEGAL;
            S_BUS_ERR:  w_stateNext = S_BUS_ERR;
            default:    w_stateNext = S_IDLE;
        endcase
    end

    // Control outputs: Moore per state, plus the Mealy PC/IR update in the fetch ack cycle.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_write     = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        jr            = 1'b0;
        halted        = 1'b0;
        illegal       = 1'b0;
        bus_err       = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_op    = 2'b11;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 2'b11;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (opcode == OP_SLTI) ? 2'b10 : 2'b11;
            end
            S_WB_I: begin
                reg_write = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                if (opcode == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end
            end
            S_JR: begin
                pc_write = 1'b1;
                pc_src   = 2'b11;
                jr       = 1'b1;
            end
            S_HALT:    halted  = 1'b1;
            S_ILLEGAL: illegal = 1'b1;
            S_BUS_ERR: bus_err = 1'b1;
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm.
// Each step drives opcode/funct/mem_ack, pushes the expected control word into a
// scoreboard queue and records the observed word at the falling edge.
module tb_main_control_fsm;

    typedef logic [21:0] ctl_t;

    typedef struct {
        logic [3:0] op;
        logic [3:0] fn;
        logic       ack;
        ctl_t       exp;
    } step_t;

    // Control word layout, MSB first: mem_req, mem_we, iord, ir_write, pc_write,
    // pc_write_cond, pc_src[1:0], alu_src_a, alu_src_b[1:0], alu_op[1:0],
    // reg_write, reg_dst[1:0], mem_to_reg[1:0], jr, halted, illegal, bus_err.
    localparam ctl_t MREQ = 22'h200000;
    localparam ctl_t MWE  = 22'h100000;
    localparam ctl_t IORD = 22'h080000;
    localparam ctl_t IRW  = 22'h040000;
    localparam ctl_t PCW  = 22'h020000;
    localparam ctl_t PCWC = 22'h010000;
    localparam ctl_t ASA  = 22'h002000;
    localparam ctl_t RW   = 22'h000100;
    localparam ctl_t JRB  = 22'h000008;
    localparam ctl_t HLT  = 22'h000004;
    localparam ctl_t ILL  = 22'h000002;
    localparam ctl_t BERR = 22'h000001;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic [3:0] funct;
    logic       zero;
    logic       mem_ack;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       jr;
    logic       halted;
    logic       illegal;
    logic       bus_err;
    ctl_t       obs;

    int   checks;
    int   failures;
    ctl_t expQ[$];
    ctl_t obsQ[$];

    ctl_t eFetchWait, eFetchAck, eDecode, eExecR, eWbR, eAddi, eSlti, eWbI;
    ctl_t eMemAddr, eMemRd, eMemWb, eMemWr, eBranch, eJump, eJal, eJr;

    main_control_fsm #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .mem_ack       (mem_ack),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .jr            (jr),
        .halted        (halted),
        .illegal       (illegal),
        .bus_err       (bus_err)
    );

    assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
                  alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
                  jr, halted, illegal, bus_err};

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic ctl_t pcSrc(input logic [1:0] v);    return ctl_t'(v) << 14; endfunction
    function automatic ctl_t aluB(input logic [1:0] v);     return ctl_t'(v) << 11; endfunction
    function automatic ctl_t aluOp(input logic [1:0] v);    return ctl_t'(v) << 9;  endfunction
    function automatic ctl_t regDst(input logic [1:0] v);   return ctl_t'(v) << 6;  endfunction
    function automatic ctl_t memToReg(input logic [1:0] v); return ctl_t'(v) << 4;  endfunction

    function automatic step_t mk(input logic [3:0] op, input logic [3:0] fn,
                                 input logic ack, input ctl_t exp);
        step_t s;
        s.op  = op;
        s.fn  = fn;
        s.ack = ack;
        s.exp = exp;
        return s;
    endfunction

    // Drives one step per cycle (starting just after a rising edge), queues the
    // expected word and captures the observed word at the falling edge.
    task automatic applyStimulus(input step_t s[$]);
        for (int k = 0; k < s.size(); k++) begin
            opcode  = s[k].op;
            funct   = s[k].fn;
            mem_ack = s[k].ack;
            expQ.push_back(s[k].exp);
            @(negedge clk);
            obsQ.push_back(obs);
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b1;
        opcode  = 4'h0;
        funct   = 4'h0;
        zero    = 1'b0;
        mem_ack = 1'b0;
        #1 rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== 22'h0) begin
                failures++;
                $display("[TB] FAIL reset_hold[%0d]: got %h expected %h", k, obs, 22'h0);
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 22'h0) begin
            failures++;
            $display("[TB] FAIL reset_idle: got %h expected %h", obs, 22'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs !== MREQ) begin
            failures++;
            $display("[TB] FAIL reset_first_fetch: got %h expected %h", obs, MREQ);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_async_drop: mem_req got %b expected 0", mem_req);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        step_t s[$];
        ctl_t  e;
        ctl_t  o;
        s.push_back(mk(4'h0, 4'h0, 1'b1, 22'h0));
        s.push_back(mk(4'h0, 4'h0, 1'b1, eFetchAck));
        s.push_back(mk(4'h0, 4'h0, 1'b1, eDecode));
        s.push_back(mk(4'h0, 4'h0, 1'b0, eExecR));
        s.push_back(mk(4'h0, 4'h0, 1'b0, eWbR));
        s.push_back(mk(4'h0, 4'h0, 1'b0, eFetchWait));
        applyStimulus(s);
        for (int k = 0; expQ.size() > 0; k++) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL rtype[%0d]: got %h expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_load_store();
        step_t s[$];
        ctl_t  e;
        ctl_t  o;
        s.push_back(mk(4'h3, 4'h0, 1'b1, eFetchAck));
        s.push_back(mk(4'h3, 4'h0, 1'b0, eDecode));
        s.push_back(mk(4'h3, 4'h0, 1'b0, eMemAddr));
        s.push_back(mk(4'h3, 4'h0, 1'b0, eMemRd));
        s.push_back(mk(4'h3, 4'h0, 1'b0, eMemRd));
        s.push_back(mk(4'h3, 4'h0, 1'b0, eMemRd));
        s.push_back(mk(4'h3, 4'h0, 1'b1, eMemRd));
        s.push_back(mk(4'h3, 4'h0, 1'b0, eMemWb));
        s.push_back(mk(4'h4, 4'h0, 1'b0, eFetchWait));
        s.push_back(mk(4'h4, 4'h0, 1'b1, eFetchAck));
        s.push_back(mk(4'h4, 4'h0, 1'b0, eDecode));
        s.push_back(mk(4'h4, 4'h0, 1'b0, eMemAddr));
        s.push_back(mk(4'h4, 4'h0, 1'b0, eMemWr));
        s.push_back(mk(4'h4, 4'h0, 1'b0, eMemWr));
        s.push_back(mk(4'h4, 4'h0, 1'b1, eMemWr));
        s.push_back(mk(4'h4, 4'h0, 1'b0, eFetchWait));
        applyStimulus(s);
        for (int k = 0; expQ.size() > 0; k++) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL load_store[%0d]: got %h expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_branch_jump();
        step_t s[$];
        ctl_t  e;
        ctl_t  o;
        s.push_back(mk(4'h5, 4'h0, 1'b1, eFetchAck));
        s.push_back(mk(4'h5, 4'h0, 1'b0, eDecode));
        s.push_back(mk(4'h5, 4'h0, 1'b1, eBranch));
        s.push_back(mk(4'h6, 4'h0, 1'b1, eFetchAck));
        s.push_back(mk(4'h6, 4'h0, 1'b0, eDecode));
        s.push_back(mk(4'h6, 4'h0, 1'b0, eJump));
        s.push_back(mk(4'h7, 4'h0, 1'b1, eFetchAck));
        s.push_back(mk(4'h7, 4'h0, 1'b0, eDecode));
        s.push_back(mk(4'h7, 4'h0, 1'b0, eJal));
        applyStimulus(s);
        for (int k = 0; expQ.size() > 0; k++) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL branch_jump[%0d]: got %h expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_jr_immediate();
        step_t s[$];
        ctl_t  e;
        ctl_t  o;
        s.push_back(mk(4'h0, 4'h8, 1'b1, eFetchAck));
        s.push_back(mk(4'h0, 4'h8, 1'b0, eDecode));
        s.push_back(mk(4'h0, 4'h8, 1'b0, eJr));
        s.push_back(mk(4'h2, 4'h0, 1'b1, eFetchAck));
        s.push_back(mk(4'h2, 4'h0, 1'b0, eDecode));
        s.push_back(mk(4'h2, 4'h0, 1'b0, eSlti));
        s.push_back(mk(4'h2, 4'h0, 1'b0, eWbI));
        s.push_back(mk(4'h1, 4'h0, 1'b1, eFetchAck));
        s.push_back(mk(4'h1, 4'h0, 1'b0, eDecode));
        s.push_back(mk(4'h1, 4'h0, 1'b0, eAddi));
        s.push_back(mk(4'h1, 4'h0, 1'b0, eWbI));
        s.push_back(mk(4'h1, 4'h0, 1'b0, eFetchWait));
        applyStimulus(s);
        for (int k = 0; expQ.size() > 0; k++) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL jr_immediate[%0d]: got %h expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_terminal();
        step_t s[$];
        ctl_t  e;
        ctl_t  o;
        s.push_back(mk(4'hA, 4'h0, 1'b1, eFetchAck));
        s.push_back(mk(4'hA, 4'h0, 1'b0, eDecode));
        s.push_back(mk(4'hA, 4'h0, 1'b1, ILL));
        s.push_back(mk(4'h0, 4'h0, 1'b1, ILL));
        s.push_back(mk(4'h0, 4'h0, 1'b0, ILL));
        applyStimulus(s);
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 22'h0) begin
            failures++;
            $display("[TB] FAIL illegal_cleared_by_reset: got %h expected %h", obs, 22'h0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        s.delete();
        s.push_back(mk(4'hF, 4'h0, 1'b0, 22'h0));
        s.push_back(mk(4'hF, 4'h0, 1'b1, eFetchAck));
        s.push_back(mk(4'hF, 4'h0, 1'b0, eDecode));
        s.push_back(mk(4'hF, 4'h0, 1'b1, HLT));
        s.push_back(mk(4'h0, 4'h0, 1'b0, HLT));
        applyStimulus(s);
        for (int k = 0; expQ.size() > 0; k++) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL terminal[%0d]: got %h expected %h", k, o, e);
            end
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        step_t s[$];
        ctl_t  e;
        ctl_t  o;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        s.push_back(mk(4'h0, 4'h0, 1'b0, 22'h0));
        s.push_back(mk(4'h0, 4'h0, 1'b0, MREQ));
        s.push_back(mk(4'h0, 4'h0, 1'b0, MREQ));
        s.push_back(mk(4'h0, 4'h0, 1'b0, MREQ));
        s.push_back(mk(4'h0, 4'h0, 1'b0, MREQ));
        s.push_back(mk(4'h0, 4'h0, 1'b1, BERR));
        s.push_back(mk(4'h0, 4'h0, 1'b0, BERR));
        applyStimulus(s);
        for (int k = 0; expQ.size() > 0; k++) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL timeout[%0d]: got %h expected %h", k, o, e);
            end
        end
    endtask
`endif

    // Expected control words per state, then the scenario sequence.
    initial begin
        checks     = 0;
        failures   = 0;
        eFetchWait = MREQ;
        eFetchAck  = MREQ | IRW | PCW | aluB(2'b01) | aluOp(2'b11);
        eDecode    = aluB(2'b11) | aluOp(2'b11);
        eExecR     = ASA;
        eWbR       = RW | regDst(2'b01);
        eAddi      = ASA | aluB(2'b10) | aluOp(2'b11);
        eSlti      = ASA | aluB(2'b10) | aluOp(2'b10);
        eWbI       = RW;
        eMemAddr   = ASA | aluB(2'b10) | aluOp(2'b11);
        eMemRd     = MREQ | IORD;
        eMemWb     = RW | memToReg(2'b01);
        eMemWr     = MREQ | MWE | IORD;
        eBranch    = ASA | aluOp(2'b01) | PCWC | pcSrc(2'b01);
        eJump      = PCW | pcSrc(2'b10);
        eJal       = PCW | pcSrc(2'b10) | RW | regDst(2'b10) | memToReg(2'b10);
        eJr        = PCW | pcSrc(2'b11) | JRB;

        test_reset();
        test_rtype();
        test_load_store();
        test_branch_jump();
        test_jr_immediate();
        test_terminal();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/main_control_fsm.md
Name: main_control_fsm

Overview:
Multi-cycle main control unit for the 16-bit CPU. It is the producer side of the ALU-control interface: it decodes the IR opcode and funct fields and sequences the datapath through fetch, decode, execute, memory and writeback. It drives alu_op[1:0] to the downstream ALU-control decoder and asserts jr for register-indirect jumps. A single req/ack handshake is shared by instruction and data memory.

Parameters:
TIMEOUT_CYCLES, 255, maximum number of wait cycles for mem_ack before bus error (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  4  IR[15:12]
funct  in  4  IR[3:0]
zero  in  1  ALU zero flag (unused internally; beq PC gating is done in the datapath via pc_write_cond)
mem_ack  in  1  memory done; read data valid / write accepted
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1=write, 0=read
iord  out  1  address source: 0=PC, 1=ALUOut
ir_write  out  1  load IR from memory data
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if zero
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=rs (JR)
alu_src_a  out  1  0=PC, 1=rs
alu_src_b  out  2  00=rt, 01=+1, 10=sign-ext imm, 11=sign-ext offset
alu_op  out  2  00=R-type(funct), 01=sub, 10=slt, 11=add
reg_write  out  1  register file write enable
reg_dst  out  2  00=rt, 01=rd, 10=r7
mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=PC
jr  out  1  JR in progress
halted  out  1  HALT reached, sticky
illegal  out  1  undefined opcode, sticky
bus_err  out  1  memory timeout, sticky (tied 0 without MEM_TIMEOUT_EN)

Behaviour:
- Opcodes: 0000 R-type, 0001 addi, 0010 slti, 0011 lw, 0100 sw, 0101 beq, 0110 j, 0111 jal, 1111 halt; all others are illegal. R-type with funct 1000 is JR.
- Reset (asynchronous): state=IDLE, every output 0, sticky flags cleared. IDLE lasts exactly 1 cycle after rst_n deasserts, then goes to FETCH.
- Any control output not listed for a state is 0.
- FETCH: mem_req=1, iord=0.
  - Wait here while mem_ack=0.
  - In the mem_ack cycle (Mealy): ir_write=1, pc_write=1, pc_src=00, alu_src_a=0, alu_src_b=01, alu_op=11.
  - Next state: DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=11 (branch target into ALUOut). Branch on opcode:
  - R-type (funct!=1000) -> EXEC_R; JR -> JR.
  - addi/slti -> EXEC_I; lw/sw -> MEM_ADDR.
  - beq -> BRANCH; j/jal -> JUMP.
  - halt -> HALT; illegal -> ILLEGAL.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=00 -> WB_R.
- WB_R: reg_write=1, reg_dst=01, mem_to_reg=00 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10; alu_op=11 for addi, 10 for slti -> WB_I.
- WB_I: reg_write=1, reg_dst=00, mem_to_reg=00 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=11 -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_req=1, iord=1, mem_we=0. Hold until mem_ack -> MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01 -> FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1. Hold until mem_ack -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01 -> FETCH.
- JUMP: pc_write=1, pc_src=10. For jal, additionally reg_write=1, reg_dst=10, mem_to_reg=10. -> FETCH.
- JR: pc_write=1, pc_src=11, jr=1 -> FETCH.
- HALT: halted=1. ILLEGAL: illegal=1. Both are terminal until reset and issue no mem_req.
- Handshake rules:
  - mem_req, mem_we and iord stay stable from assertion until the mem_ack cycle.
  - Zero-wait ack (ack in the first req cycle) is legal.
  - mem_ack outside FETCH/MEM_RD/MEM_WR is ignored.
- Reset asserted mid-transaction drops mem_req asynchronously. Memory must tolerate an abandoned request.
- Cycle counts with zero-wait memory:
  - R-type, addi, slti: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, j, jal, JR: 3 cycles.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - An 8-bit-minimum wait counter clears on entry to FETCH/MEM_RD/MEM_WR and increments each cycle mem_ack=0.
  - When the counter reaches TIMEOUT_CYCLES without ack, the FSM goes to BUS_ERR: bus_err=1 sticky, mem_req=0, all other outputs 0, terminal until reset.
  - An ack in the same cycle the count is reached wins (no error).
- Undefined: no counter; the FSM waits indefinitely; bus_err is constant 0.

Test Plan:
1. Hold rst_n=0 for 3 cycles -> all outputs 0. Release -> 1 IDLE cycle, then mem_req=1, iord=0. Assert rst_n=0 mid-FETCH -> mem_req=0 immediately.
2. add (opcode 0000, funct 0000), zero-wait ack -> ir_write and pc_write pulse in the ack cycle; EXEC_R alu_op=00; WB_R reg_write=1, reg_dst=01; next mem_req on cycle 5.
3. lw with mem_ack delayed 3 cycles in MEM_RD -> mem_req=1, iord=1, mem_we=0 held 4 cycles; then MEM_WB reg_write=1, mem_to_reg=01. sw -> mem_we=1 for the full hold.
4. beq -> BRANCH cycle alu_op=01, pc_write_cond=1, pc_src=01. jal -> pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10.
5. R-type funct 1000 -> JR cycle jr=1, pc_src=11, pc_write=1, reg_write=0. slti -> alu_op=10, alu_src_b=10.
6. opcode 1010 -> illegal=1 sticky, no further mem_req. opcode 1111 -> halted=1. With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> bus_err=1 after 4 wait cycles, mem_req=0.
